// File: rtl/level_pump_ctrl.sv
// rtl/level_pump_ctrl.sv - sump level pump controller with flood alarm and run-timeout fault
module level_pump_ctrl #(
    parameter logic [7:0]  HIGH_TH  = 8'd200,
    parameter logic [7:0]  LOW_TH   = 8'd60,
    parameter logic [7:0]  FLOOD_TH = 8'd240,
    parameter int          DEB      = 4,
    parameter logic [15:0] MAX_RUN  = 16'd6000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_100hz,
    input  logic [7:0] level,
    input  logic       fault_clr,
    output logic       pump_on,
    output logic       flood_alarm,
    output logic       fault,
    output logic [1:0] state,
    output logic [7:0] level_q
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUMPING = 2'd1,
        S_FLOOD   = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    localparam logic [3:0] DEB_C = 4'(DEB);

    state_t      st;
    logic [2:0]  sync;
    logic        tick;
    logic [3:0]  cnt_up;
    logic [3:0]  cnt_dn;
    logic [15:0] run_cnt;

    logic        up_q;
    logic        dn_q;
    logic [3:0]  up_inc;
    logic [3:0]  dn_inc;
    logic [15:0] run_inc;
    logic        up_done;
    logic        dn_done;
    logic        run_done;
    logic        clr_exit;

    // Which samples qualify for each debounce counter depends on the current state.
    always_comb begin
        up_q = 1'b0;
        dn_q = 1'b0;
        case (st)
            S_IDLE:    up_q = (level >= HIGH_TH);
            S_PUMPING: begin
                up_q = (level >= FLOOD_TH);
                dn_q = (level <= LOW_TH);
            end
            S_FLOOD:   dn_q = (level < HIGH_TH);
            default:   ;
        endcase
        up_inc   = cnt_up + 4'd1;
        dn_inc   = cnt_dn + 4'd1;
        run_inc  = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
        up_done  = up_q && (up_inc == DEB_C);
        dn_done  = dn_q && (dn_inc == DEB_C);
        run_done = (run_inc >= MAX_RUN);
        clr_exit = (st == S_FAULT) && fault_clr && (level < HIGH_TH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            sync    <= 3'b000;
            tick    <= 1'b0;
            cnt_up  <= 4'd0;
            cnt_dn  <= 4'd0;
            run_cnt <= 16'd0;
            level_q <= 8'd0;
        end else begin
            // tick is registered so it lands exactly three clk after a clk_100hz rise
            sync <= {sync[1:0], clk_100hz};
            tick <= sync[1] & ~sync[2];
            if (tick) begin
                level_q <= level;
            end
            if (clr_exit) begin
                st     <= S_IDLE;
                cnt_up <= 4'd0;
                cnt_dn <= 4'd0;
            end else if (tick) begin
                cnt_up <= up_q ? up_inc : 4'd0;
                cnt_dn <= dn_q ? dn_inc : 4'd0;
                case (st)
                    S_IDLE: begin
                        if (up_done) begin
                            st      <= (level >= FLOOD_TH) ? S_FLOOD : S_PUMPING;
                            run_cnt <= 16'd0;
                            cnt_up  <= 4'd0;
                            cnt_dn  <= 4'd0;
                        end
                    end
                    S_PUMPING: begin
                        run_cnt <= run_inc;
                        if (up_done || dn_done || run_done) begin
                            cnt_up <= 4'd0;
                            cnt_dn <= 4'd0;
                        end
                        if (up_done) begin
                            st <= S_FLOOD;
                        end else if (dn_done) begin
                            st <= S_IDLE;
                        end else if (run_done) begin
                            st <= S_FAULT;
                        end
                    end
                    S_FLOOD: begin
                        if (dn_done) begin
                            st      <= S_PUMPING;
                            run_cnt <= 16'd0;
                            cnt_up  <= 4'd0;
                            cnt_dn  <= 4'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state       = st;
    assign pump_on     = (st == S_PUMPING) || (st == S_FLOOD);
    assign flood_alarm = (st == S_FLOOD);
    assign fault       = (st == S_FAULT);

endmodule

// File: tb/tb_level_pump_ctrl.sv
// tb/tb_level_pump_ctrl.sv - self-checking bench for level_pump_ctrl
module tb_level_pump_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_100hz;
    logic [7:0] level;
    logic       fault_clr;
    logic       pump_on;
    logic       flood_alarm;
    logic       fault;
    logic [1:0] state;
    logic [7:0] level_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] lv;
        logic       fc;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic [7:0] lv;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    level_pump_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clk_100hz   (clk_100hz),
        .level       (level),
        .fault_clr   (fault_clr),
        .pump_on     (pump_on),
        .flood_alarm (flood_alarm),
        .fault       (fault),
        .state       (state),
        .level_q     (level_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [1:0] es);
        chk({tag, " state"}, state, es);
        chk({tag, " pump_on"}, pump_on, (es == 2'd1 || es == 2'd2));
        chk({tag, " flood_alarm"}, flood_alarm, (es == 2'd2));
        chk({tag, " fault"}, fault, (es == 2'd3));
    endtask

    task automatic add(input logic [7:0] lv, input logic fc, input int n,
                       input logic [1:0] pre, input logic [1:0] fin);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.lv = lv;
            v.fc = fc;
            v.st = (i == n - 1) ? fin : pre;
            vt.push_back(v);
        end
    endtask

    // One full 100 Hz period: rise, hold, fall; expected result queued at drive time.
    task automatic do_tick(input logic [7:0] lv, input logic fc, input logic [1:0] es,
                           input logic do_chk);
        exp_t e;
        @(negedge clk);
        level     = lv;
        fault_clr = fc;
        clk_100hz = 1'b1;
        e.st = es;
        e.lv = lv;
        sb.push_back(e);
        repeat (5) @(negedge clk);
        clk_100hz = 1'b0;
        repeat (5) @(negedge clk);
        fault_clr = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (do_chk) begin
                chk_outputs("tick", e.st);
                chk("tick level_q", level_q, e.lv);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        clk_100hz = 1'b0;
        level     = 8'd0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs("reset", 2'd0);
        chk("reset level_q", level_q, 0);
        rst = 1'b0;

        add(8'd210, 1'b1, 4, 2'd0, 2'd1);
        add(8'd61,  1'b1, 5, 2'd1, 2'd1);
        add(8'd50,  1'b0, 4, 2'd1, 2'd0);
        add(8'd210, 1'b0, 3, 2'd0, 2'd0);
        add(8'd150, 1'b0, 1, 2'd0, 2'd0);
        add(8'd210, 1'b0, 4, 2'd0, 2'd1);
        add(8'd60,  1'b0, 4, 2'd1, 2'd0);
        add(8'd199, 1'b0, 5, 2'd0, 2'd0);
        add(8'd250, 1'b0, 4, 2'd0, 2'd2);
        add(8'd190, 1'b0, 4, 2'd2, 2'd1);
        add(8'd240, 1'b0, 4, 2'd1, 2'd2);
        add(8'd200, 1'b1, 4, 2'd2, 2'd2);
        add(8'd0,   1'b0, 4, 2'd2, 2'd1);
        add(8'd0,   1'b0, 4, 2'd1, 2'd0);
        add(8'd255, 1'b0, 4, 2'd0, 2'd2);
        add(8'd199, 1'b0, 4, 2'd2, 2'd1);
        add(8'd50,  1'b0, 4, 2'd1, 2'd0);
        add(8'd200, 1'b0, 3, 2'd0, 2'd0);
        add(8'd240, 1'b0, 1, 2'd0, 2'd2);
        add(8'd100, 1'b0, 4, 2'd2, 2'd1);
        add(8'd0,   1'b0, 4, 2'd1, 2'd0);

        for (int i = 0; i < vt.size(); i++) begin
            do_tick(vt[i].lv, vt[i].fc, vt[i].st, 1'b1);
        end

        // Run timeout: the 6000th PUMPING tick faults.
        for (int i = 0; i < 4; i++) do_tick(8'd210, 1'b0, (i == 3) ? 2'd1 : 2'd0, 1'b1);
        for (int i = 1; i <= 6000; i++) begin
            do_tick(8'd150, 1'b0, (i == 6000) ? 2'd3 : 2'd1, (i >= 5998));
        end
        for (int i = 0; i < 2; i++) do_tick(8'd250, 1'b0, 2'd3, 1'b1);

        @(negedge clk);
        level     = 8'd210;
        fault_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs("clr high level", 2'd3);
        level = 8'd100;
        @(posedge clk);
        #1;
        chk_outputs("clr low level", 2'd0);
        @(negedge clk);
        fault_clr = 1'b0;

        // Reset from FLOOD.
        for (int i = 0; i < 4; i++) do_tick(8'd250, 1'b0, (i == 3) ? 2'd2 : 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs("rst in flood", 2'd0);
        chk("rst in flood level_q", level_q, 0);
        @(negedge clk);
        rst = 1'b0;

        // Tick timing: tick on the 3rd edge after the rise, level_q captured on the 4th.
        for (int r = 0; r < 2; r++) begin
            repeat (4) @(negedge clk);
            level     = 8'd77 + 8'(r);
            clk_100hz = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("tick edge %0d", k), dut.tick, (k == 3));
                if (k == 3) chk("level_q before tick edge", level_q, (r == 0) ? 0 : 77);
                if (k == 4) chk("level_q on tick edge", level_q, 77 + r);
            end
            repeat (4) @(negedge clk);
            clk_100hz = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
